led_panel_scan: RTL and testbench

HUB75-style LED panel scan driver clocked from the clock divider's 20 MHz output. It reads colour data from a synchronous frame buffer, shifts one bit-plane of a row pair into the panel and latches it. It then enables the LEDs for a binary-weighted time, cycling through all bit-planes and rows to produce BPP-bit-per-colour brightness. It is the consumer of the divided clock and drives the panel connector pins directly.

---
 rtl/led_panel_scan.sv | 203 ++++++++++++++++++++
 tb/tb_led_panel_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/led_panel_scan.sv
`timescale 1ns/1ps
// HUB75-style LED panel scan driver.
// Fetches one bit-plane of a row pair from a 1-cycle-latency frame buffer,
// shifts it into the panel, latches it, then lights the LEDs for a
// binary-weighted time. Planes and row pairs are cycled to build the frame.
module led_panel_scan #(
    parameter int COLS       = 64,
    parameter int COL_W      = 6,
    parameter int ROW_ADDR_W = 4,
    parameter int BPP        = 4,
    parameter int DISP_BASE  = 8
) (
    input  logic                        clk_in,
    input  logic                        ar,
    input  logic                        en,
    output logic [ROW_ADDR_W+COL_W-1:0] pix_addr,
    input  logic [6*BPP-1:0]            pix_data,
    output logic                        panel_clk,
    output logic                        panel_lat,
    output logic                        panel_oe_n,
    output logic [ROW_ADDR_W-1:0]       panel_row,
    output logic [5:0]                  rgb,
    output logic                        frame_done
);

    // The longest display run is DISP_BASE<<(BPP-1); the counter must hold it.
    localparam int DISP_MAX = DISP_BASE << (BPP - 1);
    localparam int DISP_W   = $clog2(DISP_MAX + 1);
    localparam int PLANE_W  = (BPP > 1) ? $clog2(BPP) : 1;

    localparam logic [PLANE_W-1:0]    LAST_PLANE = PLANE_W'(BPP - 1);
    localparam logic [ROW_ADDR_W-1:0] LAST_ROW   = '1;
    localparam logic [COL_W-1:0]      LAST_COL   = COL_W'(COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_LATCH,
        S_DISPLAY
    } state_t;

    state_t                  state_q, state_n;
    logic                    fcnt_q, fcnt_n;    // FETCH cycle index (0/1)
    logic                    phase_q, phase_n;  // SHIFT: 0 = data cycle, 1 = clock-high cycle
    logic [COL_W-1:0]        col_q, col_n;
    logic [ROW_ADDR_W-1:0]   row_q, row_n;
    logic [PLANE_W-1:0]      plane_q, plane_n;
    logic [DISP_W-1:0]       disp_q, disp_n;

    logic [ROW_ADDR_W+COL_W-1:0] pix_addr_n;
    logic                        panel_clk_n;
    logic                        panel_lat_n;
    logic                        panel_oe_n_n;
    logic [ROW_ADDR_W-1:0]       panel_row_n;
    logic [5:0]                  rgb_n;
    logic                        frame_done_n;

    logic [5:0]        plane_bits;  // current plane's bit of each colour field
    logic [DISP_W-1:0] disp_last;   // final display count for the current plane
    logic              frame_last;  // current plane is the last one of the frame

    // Pick bit plane_q out of each of the six BPP-wide colour fields.
    for (genvar k = 0; k < 6; k++) begin : g_sel
        logic [BPP-1:0] field;
        assign field         = pix_data[k*BPP +: BPP];
        assign plane_bits[k] = field[plane_q];
    end

    assign disp_last  = DISP_W'((DISP_BASE << plane_q) - 1);
    assign frame_last = (plane_q == LAST_PLANE) && (row_q == LAST_ROW);

    // State, counters and all panel outputs are registered together.
    always_ff @(posedge clk_in or negedge ar) begin
        if (!ar) begin
            state_q    <= S_IDLE;
            fcnt_q     <= 1'b0;
            phase_q    <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            plane_q    <= '0;
            disp_q     <= '0;
            pix_addr   <= '0;
            panel_clk  <= 1'b0;
            panel_lat  <= 1'b0;
            panel_oe_n <= 1'b1;
            panel_row  <= '0;
            rgb        <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q    <= state_n;
            fcnt_q     <= fcnt_n;
            phase_q    <= phase_n;
            col_q      <= col_n;
            row_q      <= row_n;
            plane_q    <= plane_n;
            disp_q     <= disp_n;
            pix_addr   <= pix_addr_n;
            panel_clk  <= panel_clk_n;
            panel_lat  <= panel_lat_n;
            panel_oe_n <= panel_oe_n_n;
            panel_row  <= panel_row_n;
            rgb        <= rgb_n;
            frame_done <= frame_done_n;
        end
    end

    // Next-state logic; outputs are computed for the cycle being entered.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_n      = state_q;
        fcnt_n       = fcnt_q;
        phase_n      = phase_q;
        col_n        = col_q;
        row_n        = row_q;
        plane_n      = plane_q;
        disp_n       = disp_q;
        pix_addr_n   = pix_addr;
        panel_row_n  = panel_row;
        rgb_n        = rgb;
        panel_clk_n  = 1'b0;
        panel_lat_n  = 1'b0;
        panel_oe_n_n = 1'b1;
        frame_done_n = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_n    = S_FETCH;
                    fcnt_n     = 1'b0;
                    row_n      = '0;
                    plane_n    = '0;
                    pix_addr_n = '0;
                end
            end

            S_FETCH: begin
                if (!fcnt_q) begin
                    fcnt_n = 1'b1;
                end else begin
                    // Column 0 data arrives now; column 1 address goes out
                    // so the read stays two cycles ahead of rgb.
                    state_n = S_SHIFT;
                    col_n   = '0;
                    phase_n = 1'b0;
                    rgb_n   = plane_bits;
                    if (COLS > 1) pix_addr_n = {row_q, COL_W'(1)};
                end
            end

            S_SHIFT: begin
                if (!phase_q) begin
                    phase_n     = 1'b1;
                    panel_clk_n = 1'b1;
                end else if (col_q != LAST_COL) begin
                    phase_n = 1'b0;
                    col_n   = col_q + COL_W'(1);
                    rgb_n   = plane_bits;
                    if (int'(col_q) + 2 < COLS) pix_addr_n = {row_q, col_q + COL_W'(2)};
                end else begin
                    state_n     = S_LATCH;
                    panel_lat_n = 1'b1;
                    panel_row_n = row_q;
                end
            end

            S_LATCH: begin
                state_n      = S_DISPLAY;
                disp_n       = '0;
                panel_oe_n_n = 1'b0;
                frame_done_n = (disp_last == '0) && frame_last;
            end

            S_DISPLAY: begin
                if (disp_q != disp_last) begin
                    disp_n       = disp_q + DISP_W'(1);
                    panel_oe_n_n = 1'b0;
                    frame_done_n = ((disp_q + DISP_W'(1)) == disp_last) && frame_last;
                end else if (plane_q != LAST_PLANE) begin
                    state_n    = S_FETCH;
                    fcnt_n     = 1'b0;
                    plane_n    = plane_q + PLANE_W'(1);
                    pix_addr_n = {row_q, {COL_W{1'b0}}};
                end else begin
                    plane_n = '0;
                    row_n   = row_q + ROW_ADDR_W'(1);
                    if (row_q == LAST_ROW && !en) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n    = S_FETCH;
                        fcnt_n     = 1'b0;
                        pix_addr_n = {row_n, {COL_W{1'b0}}};
                    end
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_panel_scan.sv
`timescale 1ns/1ps
// Self-checking bench for led_panel_scan with a small panel configuration.
// Expected outputs come from a per-cycle schedule derived from the frame
// timing rules and from the frame-buffer contents.
module tb_led_panel_scan;

    localparam int COLS       = 4;
    localparam int COL_W      = 2;
    localparam int ROW_ADDR_W = 1;
    localparam int BPP        = 2;
    localparam int DISP_BASE  = 2;

    localparam int ROWS       = 1 << ROW_ADDR_W;
    localparam int SHIFT_END  = 2 + 2 * COLS;   // plane offset of the LATCH cycle
    localparam int ROW_CYC    = BPP * (3 + 2 * COLS) + DISP_BASE * ((1 << BPP) - 1);
    localparam int FRAME_CYC  = ROWS * ROW_CYC;
    localparam int ADDR_W     = ROW_ADDR_W + COL_W;

    logic                 clk_in = 1'b0;
    logic                 ar;
    logic                 en;
    logic [ADDR_W-1:0]    pix_addr;
    logic [6*BPP-1:0]     pix_data;
    logic                 panel_clk;
    logic                 panel_lat;
    logic                 panel_oe_n;
    logic [ROW_ADDR_W-1:0] panel_row;
    logic [5:0]           rgb;
    logic                 frame_done;

    logic [6*BPP-1:0] mem [1 << ADDR_W];

    int checks   = 0;
    int failures = 0;

    led_panel_scan #(
        .COLS(COLS), .COL_W(COL_W), .ROW_ADDR_W(ROW_ADDR_W),
        .BPP(BPP), .DISP_BASE(DISP_BASE)
    ) dut (
        .clk_in(clk_in), .ar(ar), .en(en),
        .pix_addr(pix_addr), .pix_data(pix_data),
        .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
        .panel_row(panel_row), .rgb(rgb), .frame_done(frame_done)
    );

    always #5 clk_in = ~clk_in;

    // Frame buffer: data for the address seen at an edge appears after it.
    always @(posedge clk_in) pix_data <= mem[pix_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int t, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    function automatic logic [13:0] out_vec();
        return {pix_addr, panel_clk, panel_lat, panel_oe_n, panel_row, rgb, frame_done};
    endfunction

    localparam logic [13:0] RST_VEC = {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 6'b000000, 1'b0};

    // Expected outputs for cycle t of a frame (t=0 is the first FETCH cycle).
    task automatic check_cycle(input int t, input bit first_frame);
        int tr, r, p, u, off, len, c, acol, exp_row;
        logic [6*BPP-1:0] word;
        logic [BPP-1:0] r_top, g_top, b_top, r_bot, g_bot, b_bot;
        logic [5:0] exp_rgb;
        tr  = t % ROW_CYC;
        r   = t / ROW_CYC;
        p   = 0;
        off = 0;
        while (tr - off >= 3 + 2 * COLS + (DISP_BASE << p)) begin
            off += 3 + 2 * COLS + (DISP_BASE << p);
            p++;
        end
        u   = tr - off;
        len = DISP_BASE << p;

        check("panel_clk",  t, 32'(panel_clk),  32'(u >= 2 && u < SHIFT_END && ((u - 2) % 2) == 1));
        check("panel_lat",  t, 32'(panel_lat),  32'(u == SHIFT_END));
        check("panel_oe_n", t, 32'(panel_oe_n), 32'(!(u > SHIFT_END)));
        check("frame_done", t, 32'(frame_done),
              32'(r == ROWS - 1 && p == BPP - 1 && u == SHIFT_END + len));

        if (u >= SHIFT_END || p > 0)  exp_row = r;
        else if (first_frame && r == 0) exp_row = 0;
        else                            exp_row = (r + ROWS - 1) % ROWS;
        check("panel_row", t, 32'(panel_row), 32'(exp_row));

        if (u < 2)              acol = 0;
        else if (u < SHIFT_END) acol = ((u - 2) / 2 + 1 < COLS) ? (u - 2) / 2 + 1 : COLS - 1;
        else                    acol = COLS - 1;
        check("pix_addr", t, 32'(pix_addr), 32'((r << COL_W) | acol));

        if (u >= 2) begin
            c     = (u < SHIFT_END) ? (u - 2) / 2 : COLS - 1;
            word  = mem[(r << COL_W) | c];
            {r_top, g_top, b_top, r_bot, g_bot, b_bot} = word;
            exp_rgb = {r_top[p], g_top[p], b_top[p], r_bot[p], g_bot[p], b_bot[p]};
            check("rgb", t, 32'(rgb), 32'(exp_rgb));
        end
    endtask

    // Runs one frame starting at the next edge. en is dropped after cycle
    // drop_en_at; the run stops early after cycle abort_at.
    task automatic run_frame(input bit first_frame, input int drop_en_at, input int abort_at);
        int  fd_cnt = 0;
        int  first_rise = -1;
        int  rises [ROWS * BPP];
        bit  aborted = 1'b0;
        logic prev_clk = 1'b0;
        int  w, tr, pl;
        foreach (rises[i]) rises[i] = 0;
        for (int t = 0; t < FRAME_CYC; t++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            check_cycle(t, first_frame);
            if (frame_done) fd_cnt++;
            if (panel_clk && !prev_clk) begin
                tr = t % ROW_CYC;
                pl = (tr < 3 + 2 * COLS + DISP_BASE) ? 0 : 1;
                w  = (t / ROW_CYC) * BPP + pl;
                rises[w]++;
                if (first_rise < 0) first_rise = t;
            end
            prev_clk = panel_clk;
            if (t == drop_en_at) en = 1'b0;
            if (t == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        check("first_clk_rise_latency", 0, 32'(first_rise + 1), 32'd4);
        if (!aborted) begin
            check("frame_done_count", 0, 32'(fd_cnt), 32'd1);
            foreach (rises[i]) check("clk_rises_per_plane", i, 32'(rises[i]), 32'(COLS));
        end
    endtask

    task automatic randomize_mem();
        foreach (mem[a]) mem[a] = (6*BPP)'($urandom);
    endtask

    initial begin
        ar = 1'b0;
        en = 1'b0;
        foreach (mem[a]) mem[a] = '0;

        // Reset held while en toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            en = ~en;
            check("reset_hold", i, 32'(out_vec()), 32'(RST_VEC));
        end

        // Release reset with en low: stays idle.
        @(negedge clk_in);
        en = 1'b0;
        ar = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check("idle_after_reset", i, 32'(out_vec()), 32'(RST_VEC));
        end

        // Directed plane-select pattern, alternating per column.
        foreach (mem[a]) mem[a] = (a % 2 == 0) ? 12'hA5A : 12'h5A5;
        en = 1'b1;
        run_frame(1'b1, -1, -1);

        // Back-to-back frames with random frame-buffer contents.
        for (int f = 0; f < 2; f++) begin
            randomize_mem();
            run_frame(1'b0, -1, -1);
        end

        // en dropped mid-frame: the frame completes, then idle.
        randomize_mem();
        run_frame(1'b0, 20, -1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("idle_oe_n", i, 32'(panel_oe_n), 32'd1);
            check("idle_clk_lat_done", i, 32'({panel_clk, panel_lat, frame_done}), 32'd0);
            check("idle_panel_row", i, 32'(panel_row), 32'(ROWS - 1));
        end

        // Reset pulsed during SHIFT of row 1.
        randomize_mem();
        en = 1'b1;
        run_frame(1'b0, -1, ROW_CYC + 4);
        #2 ar = 1'b0;
        #1 check("async_reset", 0, 32'(out_vec()), 32'(RST_VEC));
        @(negedge clk_in);
        check("reset_mid_frame_hold", 0, 32'(out_vec()), 32'(RST_VEC));
        @(negedge clk_in);
        ar = 1'b1;
        run_frame(1'b1, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
